// File: rtl/ysyx_24110006_wbu_pkg.sv
// ysyx_24110006_wbu_pkg: shared encodings for the write-back unit (result select, load funct3, reset PC, FSM state)
package ysyx_24110006_wbu_pkg;
  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_CSR  = 2'd3;
  localparam logic [2:0] LOAD_FN_LB  = 3'd0;
  localparam logic [2:0] LOAD_FN_LH  = 3'd1;
  localparam logic [2:0] LOAD_FN_LW  = 3'd2;
  localparam logic [2:0] LOAD_FN_LBU = 3'd4;
  localparam logic [2:0] LOAD_FN_LHU = 3'd5;
  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  typedef enum logic {EMPTY, FULL} wbu_state_t;
endpackage

// File: rtl/ysyx_24110006_wbu_load_ext.sv
// ysyx_24110006_load_ext: combinational load aligner/sign-extender; raw word + funct3 + byte offset -> data
module ysyx_24110006_load_ext
  import ysyx_24110006_wbu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] raw,
  input  logic [2:0]            fn,
  input  logic [1:0]            off,
  output logic [DATA_WIDTH-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = off[1] ? (off[0] ? raw[31:24] : raw[23:16]) : (off[0] ? raw[15:8] : raw[7:0]);
    h = off[1] ? raw[31:16] : raw[15:0];
    data = fn == LOAD_FN_LB  ? {{(DATA_WIDTH-8){b[7]}}, b} :
           fn == LOAD_FN_LBU ? {{(DATA_WIDTH-8){1'b0}}, b} :
           fn == LOAD_FN_LH  ? {{(DATA_WIDTH-16){h[15]}}, h} :
           fn == LOAD_FN_LHU ? {{(DATA_WIDTH-16){1'b0}}, h} : raw;
  end
endmodule

// File: rtl/ysyx_24110006_wbu.sv
// ysyx_24110006_wbu: one-entry write-back stage; LSU handshake in, register-file write + IFU commit out
//   upstream:  i_valid/o_ready, i_rd, i_rd_wen, i_wb_sel, i_alu_result, i_load_raw, i_load_fn, i_csr_rdata, i_pc, i_next_pc
//   regfile:   o_rf_waddr, o_rf_wdata, o_rf_wen (registered), o_rf_valid (= retire)
//   commit:    o_commit_valid/i_commit_ready, o_commit_pc, o_next_pc
//   WBU_FWD_EN adds o_fwd_valid, o_fwd_rd, o_fwd_data for the decode bypass
module ysyx_24110006_wbu
  import ysyx_24110006_wbu_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_rd,
  input  logic                  i_rd_wen,
  input  logic [1:0]            i_wb_sel,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic [DATA_WIDTH-1:0] i_load_raw,
  input  logic [2:0]            i_load_fn,
  input  logic [DATA_WIDTH-1:0] i_csr_rdata,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_next_pc,
  output logic [ADDR_WIDTH-1:0] o_rf_waddr,
  output logic [DATA_WIDTH-1:0] o_rf_wdata,
  output logic                  o_rf_wen,
  output logic                  o_rf_valid,
  output logic                  o_commit_valid,
  input  logic                  i_commit_ready,
  output logic [DATA_WIDTH-1:0] o_commit_pc,
`ifdef WBU_FWD_EN
  output logic                  o_fwd_valid,
  output logic [ADDR_WIDTH-1:0] o_fwd_rd,
  output logic [DATA_WIDTH-1:0] o_fwd_data,
`endif
  output logic [DATA_WIDTH-1:0] o_next_pc
);
  wbu_state_t state_q, state_d;
  logic accept, retire;
  logic [DATA_WIDTH-1:0] load_data, wb_data;
  ysyx_24110006_load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
    .raw  (i_load_raw),
    .fn   (i_load_fn),
    .off  (i_alu_result[1:0]),
    .data (load_data)
  );
  // commit is masked during reset so a discarded entry never reaches the register file
  always_comb begin
    o_commit_valid = (state_q == FULL) & ~i_reset;
    o_ready = (state_q == EMPTY) | i_commit_ready;
    retire = o_commit_valid & i_commit_ready;
    accept = i_valid & o_ready;
    o_rf_valid = retire;
    state_d = accept ? FULL : retire ? EMPTY : state_q;
    wb_data = i_wb_sel == WB_SEL_LOAD ? load_data :
              i_wb_sel == WB_SEL_PC4  ? i_pc + DATA_WIDTH'(4) :
              i_wb_sel == WB_SEL_CSR  ? i_csr_rdata : i_alu_result;
  end
  always_ff @(posedge i_clock)
    if (i_reset) state_q <= EMPTY;
    else state_q <= state_d;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
      o_rf_wen <= 1'b0;
      o_commit_pc <= '0;
      o_next_pc <= '0;
    end else if (accept) begin
      o_rf_waddr <= i_rd;
      o_rf_wdata <= wb_data;
      o_rf_wen <= i_rd_wen & (i_rd != '0);
      o_commit_pc <= i_pc;
      o_next_pc <= i_next_pc;
    end
  end
`ifdef WBU_FWD_EN
  assign o_fwd_valid = o_commit_valid & o_rf_wen;
  assign o_fwd_rd = o_rf_waddr;
  assign o_fwd_data = o_rf_wdata;
`endif
endmodule

// File: tb/tb_ysyx_24110006_wbu.sv
// tb_ysyx_24110006_wbu: directed self-checking bench for the write-back unit
module tb_ysyx_24110006_wbu;
  logic i_clock = 0, i_reset = 1, i_valid = 0, i_rd_wen = 0, i_commit_ready = 0;
  logic [4:0] i_rd = 0;
  logic [1:0] i_wb_sel = 0;
  logic [2:0] i_load_fn = 0;
  logic [31:0] i_alu_result = 0, i_load_raw = 0, i_csr_rdata = 0, i_pc = 0, i_next_pc = 0;
  logic o_ready, o_rf_wen, o_rf_valid, o_commit_valid;
  logic [4:0] o_rf_waddr;
  logic [31:0] o_rf_wdata, o_commit_pc, o_next_pc;
`ifdef WBU_FWD_EN
  logic o_fwd_valid;
  logic [4:0] o_fwd_rd;
  logic [31:0] o_fwd_data;
`endif
  int compared = 0, mismatched = 0;
  ysyx_24110006_wbu dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_rd(i_rd), .i_rd_wen(i_rd_wen), .i_wb_sel(i_wb_sel), .i_alu_result(i_alu_result),
    .i_load_raw(i_load_raw), .i_load_fn(i_load_fn), .i_csr_rdata(i_csr_rdata),
    .i_pc(i_pc), .i_next_pc(i_next_pc), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .o_rf_wen(o_rf_wen), .o_rf_valid(o_rf_valid), .o_commit_valid(o_commit_valid),
    .i_commit_ready(i_commit_ready), .o_commit_pc(o_commit_pc),
`ifdef WBU_FWD_EN
    .o_fwd_valid(o_fwd_valid), .o_fwd_rd(o_fwd_rd), .o_fwd_data(o_fwd_data),
`endif
    .o_next_pc(o_next_pc)
  );
  always #5 i_clock = ~i_clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask
  task automatic put(input logic [4:0] rd, input logic wen, input logic [1:0] sel, input logic [31:0] alu,
                     input logic [31:0] raw, input logic [2:0] fn, input logic [31:0] csr, input logic [31:0] pc);
    i_valid = 1; i_rd = rd; i_rd_wen = wen; i_wb_sel = sel; i_alu_result = alu;
    i_load_raw = raw; i_load_fn = fn; i_csr_rdata = csr; i_pc = pc; i_next_pc = pc + 32'd8;
  endtask
  // one entry through an empty unit with commit ready held high
  task automatic run(input string tag, input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                     input logic [31:0] alu, input logic [31:0] raw, input logic [2:0] fn,
                     input logic [31:0] csr, input logic [31:0] pc, input logic [31:0] exp_data,
                     input logic exp_wen);
    put(rd, wen, sel, alu, raw, fn, csr, pc);
    tick();
    i_valid = 0;
    #1;
    chk({tag, "_rfv"}, 32'(o_rf_valid), 32'd1);
    chk({tag, "_data"}, o_rf_wdata, exp_data);
    chk({tag, "_wen"}, 32'(o_rf_wen), 32'(exp_wen));
    chk({tag, "_addr"}, 32'(o_rf_waddr), 32'(rd));
    tick();
    chk({tag, "_done"}, 32'(o_rf_valid), 32'd0);
  endtask
  logic       cr_seq  [5] = '{0, 1, 0, 1, 1};
  logic       vld_seq [5] = '{1, 1, 1, 1, 0};
  int         ent_seq [5] = '{0, 1, 2, 2, 0};
  logic       rdy_exp [5] = '{1, 1, 0, 1, 1};
  logic       rfv_exp [5] = '{0, 1, 0, 1, 1};
  logic [31:0] dat_exp [5] = '{32'h0, 32'hA1, 32'hB2, 32'hB2, 32'hC3};
  logic [31:0] pc_exp  [5] = '{32'h0, 32'h10, 32'h14, 32'h14, 32'h18};
  int retired;
  initial begin
    tick(); tick();
    chk("rst_cv", 32'(o_commit_valid), 32'd0);
    chk("rst_rfv", 32'(o_rf_valid), 32'd0);
    chk("rst_wdata", o_rf_wdata, 32'd0);
    chk("rst_npc", o_next_pc, 32'd0);
    i_reset = 0;
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    put(5'd3, 1, 2'd0, 32'hAA, 0, 0, 0, 32'h40);
    tick();
    i_valid = 0;
    #1;
    chk("midfull_cv", 32'(o_commit_valid), 32'd1);
    chk("midfull_pc", o_commit_pc, 32'h40);
    chk("midfull_npc", o_next_pc, 32'h48);
    chk("hold_rfv", 32'(o_rf_valid), 32'd0);
    tick();
    chk("hold_cv", 32'(o_commit_valid), 32'd1);
    i_reset = 1;
    tick();
    i_reset = 0;
    i_commit_ready = 1;
    #1;
    chk("postrst_cv", 32'(o_commit_valid), 32'd0);
    chk("postrst_rfv", 32'(o_rf_valid), 32'd0);
    tick();
    chk("postrst_rfv2", 32'(o_rf_valid), 32'd0);
    run("alu", 5'd5, 1, 2'd0, 32'h1234, 0, 0, 0, 32'h100, 32'h1234, 1);
    run("x0", 5'd0, 1, 2'd0, 32'h55, 0, 0, 0, 32'h104, 32'h55, 0);
    run("nowen", 5'd7, 0, 2'd3, 0, 0, 0, 32'h99, 32'h108, 32'h99, 0);
    run("rd16", 5'd16, 1, 2'd3, 0, 0, 0, 32'hDEADBEEF, 32'h10C, 32'hDEADBEEF, 1);
    run("lb1", 5'd1, 1, 2'd1, 32'h1001, 32'h80FF7F01, 3'd0, 0, 0, 32'h0000007F, 1);
    run("lb2", 5'd1, 1, 2'd1, 32'h1002, 32'h80FF7F01, 3'd0, 0, 0, 32'hFFFFFFFF, 1);
    run("lbu3", 5'd1, 1, 2'd1, 32'h1003, 32'h80FF7F01, 3'd4, 0, 0, 32'h00000080, 1);
    run("lh2", 5'd1, 1, 2'd1, 32'h1002, 32'h80FF7F01, 3'd1, 0, 0, 32'hFFFF80FF, 1);
    run("lh3", 5'd1, 1, 2'd1, 32'h1003, 32'h80FF7F01, 3'd1, 0, 0, 32'hFFFF80FF, 1);
    run("lhu0", 5'd1, 1, 2'd1, 32'h1000, 32'h80FF7F01, 3'd5, 0, 0, 32'h00007F01, 1);
    run("lw", 5'd1, 1, 2'd1, 32'h1003, 32'h80FF7F01, 3'd2, 0, 0, 32'h80FF7F01, 1);
    run("lfn7", 5'd1, 1, 2'd1, 32'h1001, 32'h80FF7F01, 3'd7, 0, 0, 32'h80FF7F01, 1);
    run("pc4wrap", 5'd1, 1, 2'd2, 0, 0, 0, 0, 32'hFFFFFFFC, 32'h00000000, 1);
    retired = 0;
    for (int c = 0; c < 5; c++) begin
      i_commit_ready = cr_seq[c];
      if (vld_seq[c]) put(5'(ent_seq[c] + 1), 1, 2'd0, 32'hA1 + 32'(ent_seq[c]) * 32'h11, 0, 0, 0, 32'h10 + 32'(ent_seq[c]) * 4);
      else i_valid = 0;
      #1;
      chk($sformatf("bp%0d_ready", c), 32'(o_ready), 32'(rdy_exp[c]));
      chk($sformatf("bp%0d_rfv", c), 32'(o_rf_valid), 32'(rfv_exp[c]));
      if (c > 0) begin
        chk($sformatf("bp%0d_data", c), o_rf_wdata, dat_exp[c]);
        chk($sformatf("bp%0d_pc", c), o_commit_pc, pc_exp[c]);
      end
`ifdef WBU_FWD_EN
      if (c > 0) chk($sformatf("bp%0d_fwd", c), 32'(o_fwd_valid), 32'd1);
`endif
      if (o_rf_valid) retired++;
      tick();
    end
    i_valid = 0;
    #1;
    chk("bp_retired", 32'(retired), 32'd3);
    chk("bp_empty_cv", 32'(o_commit_valid), 32'd0);
    chk("bp_empty_rfv", 32'(o_rf_valid), 32'd0);
    chk("bp_empty_ready", 32'(o_ready), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ysyx_24110006_wbu.md
Name: ysyx_24110006_wbu

Overview:
- Write-back unit: final pipeline stage directly upstream of the RV32E register file.
- Accepts a completed instruction from the LSU over a valid/ready handshake and holds it in a one-entry pipeline register.
- Selects and formats the write-back value (ALU / load / PC+4 / CSR) and drives the register-file write port.
- Retires the instruction to the IFU through a commit valid/ready handshake that carries the next PC.

Parameters:
- ADDR_WIDTH, 5, register index width (register file decodes only [3:0]).
- DATA_WIDTH, 32, data and PC width.

Ports:
- i_clock  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream entry valid.
- o_ready  out  1  WBU can accept an entry this cycle.
- i_rd  in  ADDR_WIDTH  destination register.
- i_rd_wen  in  1  instruction writes rd.
- i_wb_sel  in  2  result source: 0 ALU, 1 LOAD, 2 PC+4, 3 CSR.
- i_alu_result  in  DATA_WIDTH  ALU result; for loads, the byte address.
- i_load_raw  in  DATA_WIDTH  aligned 32-bit word read from memory.
- i_load_fn  in  3  load funct3.
- i_csr_rdata  in  DATA_WIDTH  CSR old value.
- i_pc  in  DATA_WIDTH  instruction PC.
- i_next_pc  in  DATA_WIDTH  resolved next PC.
- o_rf_waddr  out  ADDR_WIDTH  to register file i_waddr.
- o_rf_wdata  out  DATA_WIDTH  to register file i_wdata.
- o_rf_wen  out  1  to register file i_wen.
- o_rf_valid  out  1  to register file i_valid; pulses for exactly one cycle per retired instruction.
- o_commit_valid  out  1  held entry ready to retire.
- i_commit_ready  in  1  IFU accepts retirement.
- o_commit_pc  out  DATA_WIDTH  PC of the held entry.
- o_next_pc  out  DATA_WIDTH  next PC of the held entry.

Behaviour:
- States:
  - EMPTY: o_commit_valid=0, o_ready=1.
  - FULL: o_commit_valid=1, o_ready=i_commit_ready.
- Definitions: accept = i_valid & o_ready; retire = o_commit_valid & i_commit_ready.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + retire + accept -> FULL, with the new entry replacing the old one (back-to-back, one instruction per cycle).
  - FULL + retire with no accept -> EMPTY.
  - FULL with no retire -> FULL; held entry and all outputs stable.
- Latency: entry accepted at edge N is presented from cycle N+1; the register file writes at the first edge where retire=1.
- o_rf_valid = retire, combinational. o_rf_waddr, o_rf_wdata and o_rf_wen come from registered state only.
- o_rf_wen = held rd_wen & (held rd != 0). x0 is never written. rd[4] is passed through unchanged.
- Write-back data is computed at accept time and registered, so no combinational path runs from upstream to the register file. Selection by i_wb_sel:
  - ALU: i_alu_result.
  - PC+4: i_pc + 4, wrapping modulo 2^32.
  - CSR: i_csr_rdata.
  - LOAD: formatted as below.
- LOAD formatting, off = i_alu_result[1:0]:
  - lb (0): sign-extended byte at bits [8*off+7 : 8*off].
  - lbu (4): same byte, zero-extended.
  - lh (1): sign-extended halfword at bit 16*off[1]; off[0] is ignored.
  - lhu (5): same halfword, zero-extended.
  - lw (2), and all other codes (3, 6, 7): the raw word.
- Reset: state EMPTY; o_commit_valid=0; o_rf_valid=0; all registered outputs 0. A held entry is discarded with no write. Reset has priority over a simultaneous accept or retire.

Optional Feature:
- Macro: WBU_FWD_EN.
- When defined, three extra outputs are added for the decode bypass, all combinational from the held entry:
  - o_fwd_valid (1): FULL & o_rf_wen.
  - o_fwd_rd (ADDR_WIDTH): held rd.
  - o_fwd_data (DATA_WIDTH): held write-back data.
- Reset drives o_fwd_valid to 0.
- When undefined, these ports do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - WB_SEL_ALU/LOAD/PC4/CSR encodings.
  - LOAD_FN_LB/LH/LW/LBU/LHU funct3 constants.
  - Reset PC constant.
- One natural sub-module: ysyx_24110006_load_ext, the combinational load aligner and sign extender (raw word, funct3, offset -> data).

Test Plan:
- Reset mid-FULL, i_commit_ready=0: after reset, o_commit_valid=0, and o_rf_valid stays 0 on the following cycle.
- ALU write, rd=5, data 0x1234, commit ready tied 1: o_rf_valid pulses for one cycle with waddr=5, wdata=0x1234, wen=1.
- rd=0 with rd_wen=1: the entry retires with o_rf_wen=0.
- LOAD, raw 0x80FF7F01:
  - lb off=1 -> 0x0000007F; lb off=2 -> 0xFFFFFFFF; lbu off=3 -> 0x00000080.
  - lh off=2 -> 0xFFFF80FF; lhu off=0 -> 0x00007F01.
- PC+4 with pc=0xFFFFFFFC: wdata=0x00000000.
- Backpressure, 3 entries streamed while i_commit_ready toggles 0,1,0,1,1:
  - o_ready = i_commit_ready while FULL.
  - Each entry retires exactly once, in order; no entry is lost or duplicated.
  - One-per-cycle throughput when i_commit_ready=1.
